// File: rtl/dem_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dem_switch_sequencer
// Brief    : Sample handshake, per-block swap-bit generation and valid
//            tracking for a 3-layer DEM switching-block tree.
//            Optional DEM_SEQ_STATS_EN adds a saturating accepted-sample count.
// Revision : 1.0 - initial release
// ============================================================================
module dem_switch_sequencer #(
    parameter  int          INPUT_WIDTH = 16,
    parameter  int          LAYERS      = 3,
    parameter  logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int          NUM_SW      = 2**LAYERS - 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [1:0]             mode_i,
    input  logic                   seed_load_i,
    input  logic [15:0]            seed_i,
    input  logic                   sample_valid_i,
    output logic                   sample_ready_o,
    input  logic [INPUT_WIDTH-1:0] x_sample_i,
    output logic [INPUT_WIDTH-1:0] x_in_o,
    output logic [NUM_SW-1:0]      seq_bits_o,
    output logic                   tree_out_valid_o,
`ifdef DEM_SEQ_STATS_EN
    output logic [15:0]            accepted_cnt_o,
`endif
    output logic                   busy_o
);

    localparam int c_flush_w = (LAYERS > 1) ? $clog2(LAYERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_flush_w-1:0]   r_flush_cnt;
    logic [1:0]             r_mode;
    logic [15:0]            r_lfsr;
    logic [15:0]            w_lfsr_step;
    logic [INPUT_WIDTH-1:0] r_x_in;
    logic [NUM_SW-1:0]      r_seq;
    logic [NUM_SW-1:0]      w_seq_nxt;
    logic                   r_x_valid;
    logic [LAYERS-1:0]      r_pipe;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_start;

    assign w_ready  = (r_state == ST_RUN) && enable_i;
    assign w_accept = sample_valid_i && w_ready;
    assign w_start  = (r_state == ST_IDLE) && enable_i;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
    assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable_i)          w_state_nxt = ST_RUN;
            ST_RUN:   if (!enable_i)         w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == '0) w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_seq_nxt = r_seq;
        case (r_mode)
            2'b01:   w_seq_nxt = ~r_seq;
            2'b10:   w_seq_nxt = w_lfsr_step[NUM_SW-1:0];
            default: w_seq_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_mode      <= 2'b00;
            r_lfsr      <= LFSR_SEED;
            r_x_in      <= '0;
            r_seq       <= '0;
            r_x_valid   <= 1'b0;
            r_pipe      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_mode <= mode_i;
            end
            // FLUSH lasts LAYERS cycles: loaded with LAYERS-1, leaves at zero.
            if ((r_state == ST_RUN) && !enable_i) begin
                r_flush_cnt <= c_flush_w'(LAYERS - 1);
            end else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0)) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
            if (w_accept) begin
                r_x_in <= x_sample_i;
                r_seq  <= w_seq_nxt;
                if (r_mode == 2'b10) begin
                    r_lfsr <= w_lfsr_step;
                end
            end else if ((r_state == ST_IDLE) && seed_load_i) begin
                r_lfsr <= (seed_i == 16'h0000) ? LFSR_SEED : seed_i;
            end
            // r_x_valid marks x_in_o holding a new sample; the pipe models the tree stages.
            r_x_valid <= w_accept;
            r_pipe    <= (r_pipe << 1) | LAYERS'(r_x_valid);
        end
    end

`ifdef DEM_SEQ_STATS_EN
    logic [15:0] r_acc_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_acc_cnt <= 16'h0000;
        end else if (w_start) begin
            r_acc_cnt <= 16'h0000;
        end else if (w_accept && (r_acc_cnt != 16'hFFFF)) begin
            r_acc_cnt <= r_acc_cnt + 16'h0001;
        end
    end

    assign accepted_cnt_o = r_acc_cnt;
`endif

    assign sample_ready_o   = w_ready;
    assign x_in_o           = r_x_in;
    assign seq_bits_o       = r_seq;
    assign tree_out_valid_o = r_pipe[LAYERS-1];
    assign busy_o           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dem_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dem_switch_sequencer
// Brief    : Table-driven directed bench for dem_switch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dem_switch_sequencer;

    logic        clk;
    logic        reset_i;
    logic        enable_i;
    logic [1:0]  mode_i;
    logic        seed_load_i;
    logic [15:0] seed_i;
    logic        sample_valid_i;
    logic        sample_ready_o;
    logic [15:0] x_sample_i;
    logic [15:0] x_in_o;
    logic [6:0]  seq_bits_o;
    logic        tree_out_valid_o;
    logic        busy_o;
`ifdef DEM_SEQ_STATS_EN
    logic [15:0] accepted_cnt_o;
`endif

    int checks;
    int failures;

    dem_switch_sequencer #(
        .INPUT_WIDTH (16),
        .LAYERS      (3),
        .LFSR_SEED   (16'hACE1)
    ) u_dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .enable_i         (enable_i),
        .mode_i           (mode_i),
        .seed_load_i      (seed_load_i),
        .seed_i           (seed_i),
        .sample_valid_i   (sample_valid_i),
        .sample_ready_o   (sample_ready_o),
        .x_sample_i       (x_sample_i),
        .x_in_o           (x_in_o),
        .seq_bits_o       (seq_bits_o),
        .tree_out_valid_o (tree_out_valid_o),
`ifdef DEM_SEQ_STATS_EN
        .accepted_cnt_o   (accepted_cnt_o),
`endif
        .busy_o           (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          en;
        bit          val;
        logic [1:0]  mode;
        bit          sl;
        logic [15:0] seed;
        logic [15:0] smp;
        bit          e_rdy;
        logic [15:0] e_x;
        logic [6:0]  e_seq;
        bit          e_tov;
        bit          e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit en, input bit val, input logic [1:0] mode,
                       input bit sl, input logic [15:0] seed, input logic [15:0] smp,
                       input bit e_rdy, input logic [15:0] e_x, input logic [6:0] e_seq,
                       input bit e_tov, input bit e_busy);
        vec_t v;
        v.rst = rst; v.en = en; v.val = val; v.mode = mode; v.sl = sl; v.seed = seed;
        v.smp = smp; v.e_rdy = e_rdy; v.e_x = e_x; v.e_seq = e_seq; v.e_tov = e_tov;
        v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        enable_i       = 1'b0;
        mode_i         = 2'b00;
        seed_load_i    = 1'b0;
        seed_i         = 16'h0000;
        sample_valid_i = 1'b0;
        x_sample_i     = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic drive(input logic en, input logic val, input logic [15:0] smp);
        @(negedge clk);
        enable_i       = en;
        sample_valid_i = val;
        x_sample_i     = smp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_i  = 1'b1;
        idle_inputs();
        #2;
        chk("reset x_in", x_in_o, 0);
        chk("reset seq", seq_bits_o, 0);
        chk("reset tov", tree_out_valid_o, 0);
        chk("reset busy", busy_o, 0);
        chk("reset ready", sample_ready_o, 0);
        @(negedge clk);
        reset_i = 1'b0;

        // mode 00, back-to-back samples
        add(1,1,0,2'd0,0,16'h0,16'h0,    0,16'h0,   7'h00,0,1);
        add(0,1,1,2'd0,0,16'h0,16'hC350, 1,16'hC350,7'h00,0,1);
        add(0,1,1,2'd0,0,16'h0,16'h61A8, 1,16'h61A8,7'h00,0,1);
        add(0,1,0,2'd0,0,16'h0,16'h0,    1,16'h61A8,7'h00,0,1);
        add(0,1,0,2'd0,0,16'h0,16'h0,    1,16'h61A8,7'h00,1,1);
        add(0,1,0,2'd0,0,16'h0,16'h0,    1,16'h61A8,7'h00,1,1);
        add(0,1,0,2'd0,0,16'h0,16'h0,    1,16'h61A8,7'h00,0,1);
        // mode 01 with a bubble; mode_i changes in RUN are ignored
        add(1,1,0,2'd1,0,16'h0,16'h0, 0,16'h0,7'h00,0,1);
        add(0,1,1,2'd1,0,16'h0,16'h1, 1,16'h1,7'h7F,0,1);
        add(0,1,1,2'd1,0,16'h0,16'h2, 1,16'h2,7'h00,0,1);
        add(0,1,0,2'd1,0,16'h0,16'h0, 1,16'h2,7'h00,0,1);
        add(0,1,1,2'd0,0,16'h0,16'h3, 1,16'h3,7'h7F,1,1);
        add(0,1,1,2'd2,0,16'h0,16'h4, 1,16'h4,7'h00,1,1);
        add(0,1,0,2'd1,0,16'h0,16'h0, 1,16'h4,7'h00,0,1);
        add(0,1,0,2'd1,0,16'h0,16'h0, 1,16'h4,7'h00,1,1);
        add(0,1,0,2'd1,0,16'h0,16'h0, 1,16'h4,7'h00,1,1);
        add(0,1,0,2'd1,0,16'h0,16'h0, 1,16'h4,7'h00,0,1);
        // LFSR: seed loads in IDLE (zero -> ACE1), a seed load in RUN is ignored
        add(1,0,0,2'd0,1,16'h1234,16'h0, 0,16'h0,7'h00,0,0);
        add(0,0,0,2'd0,1,16'h0000,16'h0, 0,16'h0,7'h00,0,0);
        add(0,1,0,2'd2,0,16'h0000,16'h0, 0,16'h0,7'h00,0,1);
        add(0,1,1,2'd0,0,16'h0000,16'h7, 1,16'h7,7'h43,0,1);
        add(0,1,1,2'd0,0,16'h0000,16'h8, 1,16'h8,7'h07,0,1);
        add(0,1,0,2'd0,1,16'h1234,16'h0, 1,16'h8,7'h07,0,1);
        add(0,1,1,2'd0,0,16'h0000,16'h9, 1,16'h9,7'h0F,1,1);
        add(0,1,0,2'd0,0,16'h0000,16'h0, 1,16'h9,7'h0F,1,1);
        add(0,1,0,2'd0,0,16'h0000,16'h0, 1,16'h9,7'h0F,0,1);
        add(0,1,0,2'd0,0,16'h0000,16'h0, 1,16'h9,7'h0F,1,1);
        add(0,1,0,2'd0,0,16'h0000,16'h0, 1,16'h9,7'h0F,0,1);
        // disable after an accept: 3 FLUSH cycles, enable ignored until IDLE
        add(1,1,0,2'd0,0,16'h0,16'h0,    0,16'h0,   7'h00,0,1);
        add(0,1,1,2'd0,0,16'h0,16'hAAAA, 1,16'hAAAA,7'h00,0,1);
        add(0,0,1,2'd0,0,16'h0,16'hBBBB, 0,16'hAAAA,7'h00,0,1);
        add(0,1,1,2'd0,0,16'h0,16'hCCCC, 0,16'hAAAA,7'h00,0,1);
        add(0,1,0,2'd0,0,16'h0,16'h0,    0,16'hAAAA,7'h00,1,1);
        add(0,1,0,2'd0,0,16'h0,16'h0,    0,16'hAAAA,7'h00,0,0);
        add(0,1,0,2'd0,0,16'h0,16'h0,    0,16'hAAAA,7'h00,0,1);
        add(0,1,1,2'd0,0,16'h0,16'hDDDD, 1,16'hDDDD,7'h00,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            enable_i       = vecs[i].en;
            sample_valid_i = vecs[i].val;
            mode_i         = vecs[i].mode;
            seed_load_i    = vecs[i].sl;
            seed_i         = vecs[i].seed;
            x_sample_i     = vecs[i].smp;
            #1;
            chk($sformatf("vec%0d ready", i), sample_ready_o, vecs[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d x_in", i), x_in_o, vecs[i].e_x);
            chk($sformatf("vec%0d seq", i), seq_bits_o, vecs[i].e_seq);
            chk($sformatf("vec%0d tov", i), tree_out_valid_o, vecs[i].e_tov);
            chk($sformatf("vec%0d busy", i), busy_o, vecs[i].e_busy);
        end

        // asynchronous reset with two samples in flight
        do_reset();
        @(negedge clk);
        mode_i = 2'b01;
        drive(1'b1, 1'b0, 16'h0);
        drive(1'b1, 1'b1, 16'h1111);
        drive(1'b1, 1'b1, 16'h2222);
        chk("pre-reset seq", seq_bits_o, 7'h00);
        #2;
        reset_i = 1'b1;
        #1;
        chk("async x_in", x_in_o, 0);
        chk("async seq", seq_bits_o, 0);
        chk("async tov", tree_out_valid_o, 0);
        chk("async busy", busy_o, 0);
        chk("async ready", sample_ready_o, 0);
        @(negedge clk);
        idle_inputs();
        reset_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 16'h0);
            chk($sformatf("post-reset tov%0d", k), tree_out_valid_o, 0);
        end

`ifdef DEM_SEQ_STATS_EN
        do_reset();
        drive(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 16'(k));
        chk("stats five", accepted_cnt_o, 16'd5);
        for (int k = 0; k < 65530; k++) drive(1'b1, 1'b1, 16'h5A5A);
        chk("stats full", accepted_cnt_o, 16'hFFFF);
        drive(1'b1, 1'b1, 16'h5A5A);
        chk("stats saturate", accepted_cnt_o, 16'hFFFF);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 16'h0);
        chk("stats idle hold", accepted_cnt_o, 16'hFFFF);
        chk("stats idle busy", busy_o, 0);
        drive(1'b1, 1'b0, 16'h0);
        chk("stats cleared", accepted_cnt_o, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dem_switch_sequencer.md
Name: dem_switch_sequencer

Overview:
- Controller for the 3-layer DEM switching-block tree (1+2+4 = 7 switching blocks, 8 unit outputs).
- Accepts input samples over a valid/ready handshake and drives the tree's sample input.
- Generates one swap/sequence bit per switching block every accepted sample, selected by mode: static, alternate or LFSR-random.
- Tracks tree pipeline latency and flags when tree outputs are valid; drains the pipeline cleanly on disable.

Parameters:
- INPUT_WIDTH, 16, sample width; must match the switching tree.
- LAYERS, 3, number of tree layers; also the tree latency in cycles.
- NUM_SW, 2**LAYERS-1 (=7), number of switching blocks; localparam, not overridable.
- LFSR_SEED, 16'hACE1, LFSR reset value and substitute for an all-zero seed.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- enable_i  in  1  run request
- mode_i  in  2  00 static, 01 alternate, 10 LFSR, 11 reserved (treated as 00)
- seed_load_i  in  1  load seed_i into LFSR (IDLE only)
- seed_i  in  16  LFSR seed
- sample_valid_i  in  1  sample present
- sample_ready_o  out  1  sequencer accepts sample
- x_sample_i  in  INPUT_WIDTH  input sample
- x_in_o  out  INPUT_WIDTH  registered sample to tree
- seq_bits_o  out  NUM_SW  per-block swap bits; bit 0 = layer-1 block, bits 1-2 = layer 2, bits 3-6 = layer 3
- tree_out_valid_o  out  1  tree outputs correspond to an accepted sample
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, x_in_o=0, seq_bits_o=0, tree_out_valid_o=0, busy_o=0, lfsr=LFSR_SEED, mode_q=00, valid pipe=0.
- FSM IDLE->RUN when enable_i=1. mode_q latches mode_i on this transition; mode_i is ignored at all other times.
- FSM RUN->FLUSH when enable_i=0.
- FSM FLUSH->IDLE after exactly LAYERS cycles. enable_i during FLUSH is ignored until IDLE is reached; IDLE->RUN then follows on the next cycle.
- sample_ready_o = (state==RUN) & enable_i, combinational. Accept = sample_valid_i & sample_ready_o.
- On accept: x_in_o <= x_sample_i (1-cycle latency), and seq_bits_o updates in the same edge:
  - mode 00 / 11: all zero.
  - mode 01: invert all bits (first accept gives 7'h7F, then 7'h00, alternating).
  - mode 10: lfsr advances one step (Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0); seq_bits_o <= new lfsr[6:0].
- No accept: x_in_o, seq_bits_o and lfsr hold. Bubbles are allowed.
- Valid pipe: LAYERS-deep shift register fed with accept, shifting every cycle. tree_out_valid_o = pipe[LAYERS-1], so it is high LAYERS+1 cycles after the accept edge (register into x_in_o, plus LAYERS tree stages).
- FLUSH keeps shifting the pipe, so in-flight samples still raise tree_out_valid_o. The pipe is empty on entry to IDLE.
- seed_load_i in IDLE: lfsr <= (seed_i==0) ? LFSR_SEED : seed_i. It is ignored in RUN and FLUSH.
- Reset mid-RUN/FLUSH: immediate return to reset values; in-flight valids are discarded.
- Width: samples are passed unmodified; there is no arithmetic on the data path.

Optional Feature:
- Macro DEM_SEQ_STATS_EN.
- Defined: adds output accepted_cnt_o [15:0], counting accepted samples. It saturates at 16'hFFFF, is cleared by reset and on each IDLE->RUN transition, and holds in FLUSH/IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, enable_i=1, mode 00, samples 50000 then 25000 back-to-back -> x_in_o follows 1 cycle after each accept, seq_bits_o=0, tree_out_valid_o high for exactly 2 cycles starting 4 cycles after the first accept.
- Mode 01, 4 accepts with one bubble cycle between accepts 2 and 3 -> seq_bits_o sequence 7F,00,7F,00; the bubble cycle holds 00 and gives a one-cycle gap in tree_out_valid_o.
- IDLE, seed_load_i with seed_i=0 -> lfsr=ACE1. Mode 10, 3 accepts -> seq_bits_o equals the low 7 bits of LFSR steps 1,2,3 from ACE1 (golden model). Seed load attempted in RUN -> no effect.
- enable_i dropped the cycle after an accept -> sample_ready_o=0 immediately, busy_o high for 3 FLUSH cycles, the in-flight sample's tree_out_valid_o still asserted, then IDLE. enable_i reasserted during FLUSH -> RUN entered only after IDLE.
- reset_i asserted mid-RUN with 2 samples in flight -> all outputs reset asynchronously; no tree_out_valid_o after release.
- DEM_SEQ_STATS_EN defined: 5 accepts -> accepted_cnt_o=5; counter preloaded to FFFF plus 1 accept -> stays FFFF; cleared on the next IDLE->RUN transition.
